mem_port_ctrl: RTL and testbench
================================

// Module: mem_port_ctrl
// PURPOSE
//  Shared memory-port controller that sits directly downstream of cache_arbiter.
//  It samples the arbiter's registered grants, latches the winning cache's line
//  request, and runs one line-sized burst on the memory bus (read fill or
//  dirty-line writeback). It then returns a one-cycle response to the cache that owned the grant.
//  Exactly one transaction is in flight at a time; grants are ignored while busy.
// PARAMETERS
//  ADDR_W      64  byte address width
//  DATA_W      64  memory bus beat width (bits)
//  LINE_WORDS  8   beats per cache line; power of 2, >=2 (line = LINE_WORDS*DATA_W bits)
// PORTS
//  clk               in   1                 single clock, rising edge
//  reset             in   1                 asynchronous, active-high
//  icache_grant      in   1                 registered grant from arbiter
//  dcache_grant      in   1                 registered grant from arbiter
//  icache_addr       in   ADDR_W            I-side miss address (read only)
//  dcache_addr       in   ADDR_W            D-side address
//  dcache_we         in   1                 1 = writeback of dcache_wline, 0 = fill
//  dcache_wline      in   LINE_WORDS*DATA_W writeback line, beat0 = bits[DATA_W-1:0]
//  icache_resp_valid out  1                 1-cycle pulse: I fill complete
//  dcache_resp_valid out  1                 1-cycle pulse: D fill or writeback complete
//  resp_line         out  LINE_WORDS*DATA_W assembled fill line; valid with resp pulse
//  busy              out  1                 high in every state except IDLE
//  mem_req_valid     out  1                 burst request valid
//  mem_req_ready     in   1                 memory accepts request
//  mem_req_addr      out  ADDR_W            line-aligned address (low log2(LINE_WORDS*DATA_W/8) bits zero)
//  mem_req_write     out  1                 1 = write burst
//  mem_rvalid        in   1                 read beat valid (never in the same cycle as req accept)
//  mem_rdata         in   DATA_W            read beat
//  mem_rlast         in   1                 final read beat marker
//  mem_wvalid        out  1                 write beat valid
//  mem_wready        in   1                 memory accepts write beat
//  mem_wdata         out  DATA_W            write beat
//  mem_wlast         out  1                 final write beat marker
//  mem_bvalid        in   1                 write burst complete
//  mem_err           out  1                 sticky: rlast mismatch or both grants seen; cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, beat counter 0, owner = I, line buffer 0.
//  IDLE: dcache_grant -> latch owner = D, addr, we, and wline -> REQ.
//   Else icache_grant -> owner = I, we = 0 -> REQ. Both grants high: take D and set mem_err.
//  REQ: mem_req_valid = 1, with addr and write held stable until mem_req_ready.
//   On accept -> RDATA (we = 0) or WDATA (we = 1), with counter cleared.
//  RDATA: each mem_rvalid stores mem_rdata into slice[cnt], then cnt++.
//   The beat with cnt == LINE_WORDS-1 -> DONE.
//   If rlast disagrees with (cnt == LINE_WORDS-1), set mem_err; the count still governs.
//  WDATA: mem_wvalid = 1, wdata = wline slice[cnt], wlast = (cnt == LINE_WORDS-1).
//   Advance on mem_wready; after the last beat is accepted -> BRESP.
//  BRESP: wait for mem_bvalid -> DONE.
//  DONE: pulse the owner's resp_valid for 1 cycle; resp_line is the buffer (0 for writeback) -> COOL.
//  COOL: 2 cycles ignoring grants, which flushes the arbiter's stale registered grant -> IDLE.
//   Each cache deasserts its req in the cycle it sees its resp_valid.
//  Latency (zero wait states, read): grant seen in cycle 0, req accepted in cycle 1,
//   beats in cycles 2..LINE_WORDS+1, resp pulse in cycle LINE_WORDS+2.
//  Grants arriving in any state other than IDLE are ignored; the arbiter keeps toggling them.
//  Counter is log2(LINE_WORDS) bits and wraps to 0 only via the REQ clear.
//  Reset mid-burst: immediate return to IDLE with all outputs 0. The burst is abandoned;
//   the memory side must be reset together with this block.
// STRUCTURE
//  Package mem_if_pkg holds: state_e enum (IDLE, REQ, RDATA, WDATA, BRESP, DONE, COOL),
//   owner_e (OWN_I, OWN_D), localparams LINE_BITS and BEAT_IDX_W, and the line_t typedef.
//  Sub-module line_beat_buf holds the line register, with a beat write port (fill) and a
//   beat read mux (writeback) indexed by cnt.
//  The FSM, counter, and latches live in mem_port_ctrl.
// TESTING
//  1 I fill, zero wait: icache_grant=1 with addr 0x1234 -> mem_req_addr=0x1200 in cycle 1;
//    beats 0..7 = 0x10..0x17 -> icache_resp_valid in cycle 10, resp_line[63:0]=0x10, [511:448]=0x17.
//  2 D writeback with wready stalls: dcache_we=1, line beats 0xA0..0xA7, wready every other cycle
//    -> wdata sequence 0xA0..0xA7, wlast only on 0xA7; bvalid 3 cycles later -> dcache_resp_valid one cycle later.
//  3 Busy ignores grants: during a D fill, icache_grant toggles each cycle -> exactly one request issued;
//    only dcache_resp_valid pulses; the I request is taken after COOL.
//  4 req_ready backpressure: ready low for 5 cycles -> mem_req_valid/addr/write stable throughout;
//    no beats consumed before accept.
//  5 Protocol error: rlast asserted on beat 5 -> mem_err=1 stays set; fill completes on beat 7.
//    Both grants high in IDLE -> D served and mem_err=1.
//  6 Reset during RDATA beat 3 -> same cycle: busy=0 and all outputs 0.
//    A fresh I fill after reset release completes normally.

Source files
------------

// File: rtl/mem_port_ctrl_pkg.sv
// Shared types for the memory-port controller: FSM states, grant owner
// and the default line geometry.
package mem_if_pkg;

    localparam int DATA_W_DEF     = 64;
    localparam int LINE_WORDS_DEF = 8;
    localparam int LINE_BITS      = LINE_WORDS_DEF * DATA_W_DEF;
    localparam int BEAT_IDX_W     = $clog2(LINE_WORDS_DEF);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RDATA,
        WDATA,
        BRESP,
        DONE,
        COOL
    } state_e;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_e;

    typedef logic [LINE_BITS-1:0] line_t;

endpackage

// File: rtl/mem_port_ctrl_if.sv
// Burst memory bus: request channel, read beats, write beats and write
// completion. master = controller, slave = memory.
interface mem_port_ctrl_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_write;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rlast;
    logic              mem_wvalid;
    logic              mem_wready;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wlast;
    logic              mem_bvalid;

    modport master (
        output mem_req_valid,
        input  mem_req_ready,
        output mem_req_addr,
        output mem_req_write,
        input  mem_rvalid,
        input  mem_rdata,
        input  mem_rlast,
        output mem_wvalid,
        input  mem_wready,
        output mem_wdata,
        output mem_wlast,
        input  mem_bvalid
    );

    modport slave (
        input  mem_req_valid,
        output mem_req_ready,
        input  mem_req_addr,
        input  mem_req_write,
        output mem_rvalid,
        output mem_rdata,
        output mem_rlast,
        input  mem_wvalid,
        output mem_wready,
        input  mem_wdata,
        input  mem_wlast,
        output mem_bvalid
    );

endinterface

// File: rtl/mem_port_ctrl_line_beat_buf.sv
// Cache-line register: whole-line load for writebacks, per-beat write
// for fills, and a beat read mux feeding the write channel.
module line_beat_buf #(
    parameter int DATA_W     = 64,
    parameter int LINE_WORDS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load,
    input  logic [LINE_WORDS*DATA_W-1:0] load_line,
    input  logic                         wr_en,
    input  logic [$clog2(LINE_WORDS)-1:0] idx,
    input  logic [DATA_W-1:0]            wr_data,
    output logic [DATA_W-1:0]            rd_data,
    output logic [LINE_WORDS*DATA_W-1:0] line
);

    logic [LINE_WORDS*DATA_W-1:0] line_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_q <= '0;
        end else if (load) begin
            line_q <= load_line;
        end else if (wr_en) begin
            line_q[idx*DATA_W +: DATA_W] <= wr_data;
        end
    end

    assign rd_data = line_q[idx*DATA_W +: DATA_W];
    assign line    = line_q;

endmodule

// File: rtl/mem_port_ctrl.sv
// Single-outstanding line-burst controller between the cache arbiter and
// the shared memory port: fills, writebacks and a one-cycle response.
module mem_port_ctrl
    import mem_if_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int LINE_WORDS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         icache_grant,
    input  logic                         dcache_grant,
    input  logic [ADDR_W-1:0]            icache_addr,
    input  logic [ADDR_W-1:0]            dcache_addr,
    input  logic                         dcache_we,
    input  logic [LINE_WORDS*DATA_W-1:0] dcache_wline,
    output logic                         icache_resp_valid,
    output logic                         dcache_resp_valid,
    output logic [LINE_WORDS*DATA_W-1:0] resp_line,
    output logic                         busy,
    output logic                         mem_err,
    mem_port_ctrl_if.master              mem
);

    localparam int IW = $clog2(LINE_WORDS);
    localparam int LINE_BYTES = LINE_WORDS * DATA_W / 8;
    localparam logic [IW-1:0] LAST = IW'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] MASK = ~(ADDR_W'(LINE_BYTES - 1));

    state_e              state_q, state_d;
    owner_e              owner_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [IW-1:0]       cnt_q;
    logic                cool_q;
    logic                err_q;

    logic                idle, take, last, rbeat, wbeat;
    logic [DATA_W-1:0]   beat_rd;
    logic [LINE_WORDS*DATA_W-1:0] line;

    assign idle  = (state_q == IDLE);
    assign take  = idle && (icache_grant || dcache_grant);
    assign last  = (cnt_q == LAST);
    assign rbeat = (state_q == RDATA) && mem.mem_rvalid;
    assign wbeat = (state_q == WDATA) && mem.mem_wready;

    line_beat_buf #(
        .DATA_W     (DATA_W),
        .LINE_WORDS (LINE_WORDS)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (idle && dcache_grant && dcache_we),
        .load_line (dcache_wline),
        .wr_en     (rbeat),
        .idx       (cnt_q),
        .wr_data   (mem.mem_rdata),
        .rd_data   (beat_rd),
        .line      (line)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (take) state_d = REQ;
            REQ:     if (mem.mem_req_ready) state_d = we_q ? WDATA : RDATA;
            RDATA:   if (rbeat && last) state_d = DONE;
            WDATA:   if (wbeat && last) state_d = BRESP;
            BRESP:   if (mem.mem_bvalid) state_d = DONE;
            DONE:    state_d = COOL;
            COOL:    if (cool_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // D wins a double grant; the counter only wraps through the REQ clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= OWN_I;
            we_q    <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            cool_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (take) begin
                owner_q <= dcache_grant ? OWN_D : OWN_I;
                we_q    <= dcache_grant && dcache_we;
                addr_q  <= dcache_grant ? dcache_addr : icache_addr;
                if (dcache_grant && icache_grant) err_q <= 1'b1;
            end
            if (state_q == REQ && mem.mem_req_ready) cnt_q <= '0;
            if ((rbeat || wbeat) && !last) cnt_q <= cnt_q + 1'b1;
            if (rbeat && (mem.mem_rlast != last)) err_q <= 1'b1;
            cool_q <= (state_q == COOL) && !cool_q;
        end
    end

    always_comb begin
        mem.mem_req_valid = 1'b0;
        mem.mem_req_addr  = '0;
        mem.mem_req_write = 1'b0;
        mem.mem_wvalid    = 1'b0;
        mem.mem_wdata     = '0;
        mem.mem_wlast     = 1'b0;
        icache_resp_valid = 1'b0;
        dcache_resp_valid = 1'b0;
        resp_line         = '0;
        unique case (state_q)
            REQ: begin
                mem.mem_req_valid = 1'b1;
                mem.mem_req_addr  = addr_q & MASK;
                mem.mem_req_write = we_q;
            end
            WDATA: begin
                mem.mem_wvalid = 1'b1;
                mem.mem_wdata  = beat_rd;
                mem.mem_wlast  = last;
            end
            DONE: begin
                icache_resp_valid = (owner_q == OWN_I);
                dcache_resp_valid = (owner_q == OWN_D);
                resp_line         = we_q ? '0 : line;
            end
            default: ;
        endcase
    end

    assign busy    = !idle;
    assign mem_err = err_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl: fills, writeback with stalls, busy
// grant filtering, request backpressure, protocol errors and mid-burst reset.
module tb_mem_port_ctrl;
    import mem_if_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        icache_grant, dcache_grant;
    logic [63:0] icache_addr, dcache_addr;
    logic        dcache_we;
    line_t       dcache_wline;
    logic        icache_resp_valid, dcache_resp_valid;
    line_t       resp_line;
    logic        busy, mem_err;

    int errors = 0;
    int checks = 0;

    mem_port_ctrl_if #(.ADDR_W(64), .DATA_W(64)) mem ();

    mem_port_ctrl #(
        .ADDR_W(64), .DATA_W(64), .LINE_WORDS(8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .icache_grant      (icache_grant),
        .dcache_grant      (dcache_grant),
        .icache_addr       (icache_addr),
        .dcache_addr       (dcache_addr),
        .dcache_we         (dcache_we),
        .dcache_wline      (dcache_wline),
        .icache_resp_valid (icache_resp_valid),
        .dcache_resp_valid (dcache_resp_valid),
        .resp_line         (resp_line),
        .busy              (busy),
        .mem_err           (mem_err),
        .mem               (mem)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Eight back-to-back read beats; leaves the bench in the cycle after beat 7.
    task automatic do_beats(logic [63:0] base, int rlast_at);
        for (int i = 0; i < 8; i++) begin
            mem.mem_rvalid = 1'b1;
            mem.mem_rdata  = base + 64'(i);
            mem.mem_rlast  = (i == rlast_at);
            tick();
        end
        mem.mem_rvalid = 1'b0;
        mem.mem_rlast  = 1'b0;
        mem.mem_rdata  = '0;
    endtask

    line_t       exp_line;
    int          reqs, ip, dp;
    logic [63:0] b0, b7;

    initial begin
        reset = 1'b1;
        icache_grant = 0; dcache_grant = 0;
        icache_addr = '0; dcache_addr = '0;
        dcache_we = 0; dcache_wline = '0;
        mem.mem_req_ready = 1'b1;
        mem.mem_rvalid = 0; mem.mem_rdata = '0; mem.mem_rlast = 0;
        mem.mem_wready = 0; mem.mem_bvalid = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_req_valid", mem.mem_req_valid, 0);
        chk("rst_req_addr", mem.mem_req_addr, 0);
        chk("rst_wvalid", mem.mem_wvalid, 0);
        chk("rst_iresp", icache_resp_valid, 0);
        chk("rst_dresp", dcache_resp_valid, 0);
        chk("rst_line", resp_line, 0);
        chk("rst_err", mem_err, 0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // 1: I fill, zero wait states
        icache_grant = 1; icache_addr = 64'h1234;
        tick();
        icache_grant = 0;
        chk("s1_req_valid", mem.mem_req_valid, 1);
        chk("s1_req_addr", mem.mem_req_addr, 64'h1200);
        chk("s1_req_write", mem.mem_req_write, 0);
        tick();
        chk("s1_no_resp_early", icache_resp_valid, 0);
        do_beats(64'h10, 7);
        chk("s1_iresp", icache_resp_valid, 1);
        chk("s1_dresp", dcache_resp_valid, 0);
        chk("s1_beat0", resp_line[63:0], 64'h10);
        chk("s1_beat7", resp_line[511:448], 64'h17);
        tick();
        chk("s1_pulse_1cyc", icache_resp_valid, 0);
        chk("s1_cool_busy", busy, 1);
        tick(); tick();
        chk("s1_idle", busy, 0);

        // 2: D writeback, wready every other cycle
        for (int i = 0; i < 8; i++) dcache_wline[i*64 +: 64] = 64'hA0 + 64'(i);
        dcache_grant = 1; dcache_we = 1; dcache_addr = 64'h4088;
        tick();
        dcache_grant = 0; dcache_we = 0;
        chk("s2_req_write", mem.mem_req_write, 1);
        chk("s2_req_addr", mem.mem_req_addr, 64'h4080);
        tick();
        for (int i = 0; i < 8; i++) begin
            mem.mem_wready = 0;
            chk("s2_wvalid", mem.mem_wvalid, 1);
            chk("s2_wdata_stall", mem.mem_wdata, 64'hA0 + 64'(i));
            chk("s2_wlast_stall", mem.mem_wlast, (i == 7));
            tick();
            mem.mem_wready = 1;
            chk("s2_wdata", mem.mem_wdata, 64'hA0 + 64'(i));
            tick();
        end
        mem.mem_wready = 0;
        chk("s2_bresp_wvalid", mem.mem_wvalid, 0);
        tick(); tick();
        chk("s2_no_resp_pre_b", dcache_resp_valid, 0);
        mem.mem_bvalid = 1;
        tick();
        mem.mem_bvalid = 0;
        chk("s2_dresp", dcache_resp_valid, 1);
        chk("s2_iresp", icache_resp_valid, 0);
        chk("s2_line_zero", resp_line, 0);
        tick(); tick(); tick();
        chk("s2_idle", busy, 0);

        // 3: D fill while icache_grant toggles
        dcache_grant = 1; dcache_we = 0; dcache_addr = 64'h8040;
        icache_addr = 64'h3333;
        tick();
        dcache_grant = 0;
        reqs = 0; ip = 0; dp = 0; b0 = '0; b7 = '0;
        for (int c = 1; c <= 13; c++) begin
            icache_grant   = (c % 2 == 1);
            mem.mem_rvalid = (c >= 2 && c <= 9);
            mem.mem_rdata  = 64'(32'h20 + c - 2);
            mem.mem_rlast  = (c == 9);
            if (mem.mem_req_valid) reqs++;
            if (icache_resp_valid) ip++;
            if (dcache_resp_valid) begin
                dp++;
                b0 = resp_line[63:0];
                b7 = resp_line[511:448];
            end
            tick();
        end
        mem.mem_rvalid = 0; mem.mem_rlast = 0;
        icache_grant = 0;
        chk("s3_one_req", 64'(reqs), 1);
        chk("s3_no_iresp", 64'(ip), 0);
        chk("s3_one_dresp", 64'(dp), 1);
        chk("s3_beat0", b0, 64'h20);
        chk("s3_beat7", b7, 64'h27);
        chk("s3_i_req", mem.mem_req_valid, 1);
        chk("s3_i_addr", mem.mem_req_addr, 64'h3300);
        tick();
        do_beats(64'h30, 7);
        chk("s3_i_resp", icache_resp_valid, 1);
        tick(); tick(); tick();

        // 4: request backpressure, junk beats before accept
        mem.mem_req_ready = 0;
        icache_grant = 1; icache_addr = 64'hABCD_EF7F;
        tick();
        icache_grant = 0;
        for (int c = 1; c <= 5; c++) begin
            mem.mem_rvalid = 1; mem.mem_rdata = 64'hDEAD; mem.mem_rlast = 1;
            chk("s4_valid", mem.mem_req_valid, 1);
            chk("s4_addr", mem.mem_req_addr, 64'hABCD_EF40);
            chk("s4_write", mem.mem_req_write, 0);
            tick();
        end
        mem.mem_rvalid = 0; mem.mem_rlast = 0;
        mem.mem_req_ready = 1;
        chk("s4_valid_accept", mem.mem_req_valid, 1);
        tick();
        do_beats(64'h40, 7);
        for (int i = 0; i < 8; i++) exp_line[i*64 +: 64] = 64'h40 + 64'(i);
        chk("s4_line", resp_line, exp_line);
        chk("s4_no_err", mem_err, 0);
        tick(); tick(); tick();

        // 5a: early rlast on beat 5
        icache_grant = 1; icache_addr = 64'h5000;
        tick();
        icache_grant = 0;
        tick();
        for (int i = 0; i < 8; i++) begin
            mem.mem_rvalid = 1;
            mem.mem_rdata  = 64'h60 + 64'(i);
            mem.mem_rlast  = (i == 5);
            tick();
            if (i == 4) chk("s5_err_pre", mem_err, 0);
            if (i == 5) chk("s5_err_set", mem_err, 1);
            if (i == 5) chk("s5_not_done", icache_resp_valid, 0);
        end
        mem.mem_rvalid = 0; mem.mem_rlast = 0;
        chk("s5_done_beat7", icache_resp_valid, 1);
        chk("s5_beat7", resp_line[511:448], 64'h67);
        tick(); tick(); tick();
        chk("s5_err_sticky", mem_err, 1);
        chk("s5_idle", busy, 0);
        reset = 1;
        #1;
        chk("s5_err_clr", mem_err, 0);
        tick();
        reset = 0;
        tick();

        // 5b: both grants in IDLE
        icache_grant = 1; dcache_grant = 1; dcache_we = 0;
        icache_addr = 64'h1111; dcache_addr = 64'h7777;
        tick();
        icache_grant = 0; dcache_grant = 0;
        chk("s5b_addr_d", mem.mem_req_addr, 64'h7740);
        chk("s5b_err", mem_err, 1);
        tick();
        do_beats(64'h50, 7);
        chk("s5b_dresp", dcache_resp_valid, 1);
        chk("s5b_iresp", icache_resp_valid, 0);
        tick(); tick(); tick();

        // 6: reset during beat 3
        reset = 1; #1; tick(); reset = 0; tick();
        icache_grant = 1; icache_addr = 64'h9000;
        tick();
        icache_grant = 0;
        tick();
        for (int i = 0; i < 3; i++) begin
            mem.mem_rvalid = 1; mem.mem_rdata = 64'h60 + 64'(i);
            tick();
        end
        mem.mem_rdata = 64'h63;
        #2;
        reset = 1;
        #1;
        chk("s6_busy", busy, 0);
        chk("s6_req_valid", mem.mem_req_valid, 0);
        chk("s6_wvalid", mem.mem_wvalid, 0);
        chk("s6_iresp", icache_resp_valid, 0);
        chk("s6_line", resp_line, 0);
        chk("s6_err", mem_err, 0);
        mem.mem_rvalid = 0;
        tick();
        reset = 0;
        tick();
        icache_grant = 1; icache_addr = 64'h9040;
        tick();
        icache_grant = 0;
        chk("s6_fresh_addr", mem.mem_req_addr, 64'h9040);
        tick();
        do_beats(64'h70, 7);
        chk("s6_fresh_resp", icache_resp_valid, 1);
        chk("s6_fresh_beat0", resp_line[63:0], 64'h70);
        tick(); tick(); tick();
        chk("s6_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
